// File: rtl/mmio_port.sv
// Memory-mapped board I/O responder: synchronizes and debounces KEY/SW, latches key-press
// edges, and drives the seven-segment digits and LEDs from CPU-writable registers.
module mmio_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  addr,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [6:0]  SEG0,
  output logic [6:0]  SEG1,
  output logic [6:0]  SEG2,
  output logic [6:0]  SEG3,
  output logic [6:0]  SEG4,
  output logic [6:0]  SEG5,
  output logic [9:0]  LED
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [5:0] {
    IDX_SW    = 6'd0,
    IDX_KEY   = 6'd1,
    IDX_EDGE  = 6'd2,
    IDX_LED   = 6'd3,
    IDX_HEX   = 6'd4,
    IDX_HEXEN = 6'd5
  } reg_idx_e;

  logic [3:0]    r_key_s1, r_key_s2, r_key_stable;
  logic [9:0]    r_sw_s1, r_sw_s2;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_edge;
  logic [9:0]    r_led;
  logic [23:0]   r_hex;
  logic [5:0]    r_hexen;

  reg_idx_e      w_idx;
  logic [3:0]    w_press;
  logic [3:0]    w_clr;
  logic [31:0]   w_rd;

  assign w_idx = reg_idx_e'(addr[7:2]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_key_s1 <= '1;
      r_key_s2 <= '1;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= KEY;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // The stable state flips on the sample that would bring the counter to DEBOUNCE_CYCLES.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_key_stable <= '1;
      for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_key_s2[i] == r_key_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_key_stable[i] <= r_key_s2[i];
          r_cnt[i]        <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_press = '0;
    for (int unsigned i = 0; i < 4; i++)
      w_press[i] = r_key_stable[i] && !r_key_s2[i] && (r_cnt[i] == CNT_LAST);
  end

  assign w_clr = (wen && w_idx == IDX_EDGE) ? wdata[3:0] : 4'h0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_edge  <= '0;
      r_led   <= '0;
      r_hex   <= '0;
      r_hexen <= '1;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_press;
      if (wen) begin
        case (w_idx)
          IDX_LED:   r_led   <= wdata[9:0];
          IDX_HEX:   r_hex   <= wdata[23:0];
          IDX_HEXEN: r_hexen <= wdata[5:0];
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (w_idx)
      IDX_SW:    w_rd[9:0]  = r_sw_s2;
      IDX_KEY:   w_rd[3:0]  = ~r_key_stable;
      IDX_EDGE:  w_rd[3:0]  = r_edge;
      IDX_LED:   w_rd[9:0]  = r_led;
      IDX_HEX:   w_rd[23:0] = r_hex;
      IDX_HEXEN: w_rd[5:0]  = r_hexen;
      default:   w_rd = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  rdata <= '0;
    else if (ren) rdata <= w_rd;
  end

  function automatic logic [6:0] seg_dec(input logic [3:0] n, input logic en);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return en ? s : 7'h7F;
  endfunction

  assign SEG0 = seg_dec(r_hex[3:0],   r_hexen[0]);
  assign SEG1 = seg_dec(r_hex[7:4],   r_hexen[1]);
  assign SEG2 = seg_dec(r_hex[11:8],  r_hexen[2]);
  assign SEG3 = seg_dec(r_hex[15:12], r_hexen[3]);
  assign SEG4 = seg_dec(r_hex[19:16], r_hexen[4]);
  assign SEG5 = seg_dec(r_hex[23:20], r_hexen[5]);
  assign LED  = r_led;

endmodule
